// File: rtl/m_mem_access.sv
// m_mem_access
// Memory-stage access unit. It takes the operands held in the M pipeline
// register and runs one data-memory transaction per load/store over a req/ack
// bus. The load result is extracted from its byte lane and written into the
// W-stage register. Non-memory instructions pass straight through to W.
//
// Ports
//   clk, reset (async, active-low)
//   M_PC, M_A3, M_ALU_result, M_V2, M_mem_op   : instruction in M
//   mem_req, mem_we, mem_addr, mem_byteen,
//   mem_wdata                                  : registered bus request
//   mem_ack, mem_rdata                         : bus response
//   stall                                      : holds F/D/E/M (combinational)
//   W_PC, W_A3, W_data, W_exc                  : W-stage register
//
// Configuration macro: M_MEM_ALIGN_CHECK_EN
//   Defined   : misaligned lw/sw/lh/lhu/sh raise AdEL/AdES and skip the bus.
//   Undefined : W_exc is tied to 00. Misaligned low address bits are ignored
//               according to the access size.
module m_mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       M_PC,
    input  logic [4:0]        M_A3,
    input  logic [31:0]       M_ALU_result,
    input  logic [31:0]       M_V2,
    input  logic [3:0]        M_mem_op,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_byteen,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              stall,
    output logic [31:0]       W_PC,
    output logic [4:0]        W_A3,
    output logic [31:0]       W_data,
    output logic [1:0]        W_exc
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t state, state_nxt;

    function automatic logic is_load_op(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_LBU);
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op >= OP_SW) && (op <= OP_SB);
    endfunction

    // Loads always enable all four lanes; only sh/sb narrow the enables.
    function automatic logic [3:0] store_byteen(input logic [3:0] op,
                                                input logic [1:0] a);
        case (op)
            OP_SH:   return a[1] ? 4'b1100 : 4'b0011;
            OP_SB:   return 4'b0001 << a;
            default: return 4'b1111;
        endcase
    endfunction

    // Narrow store data is replicated across lanes so the byte enables alone
    // pick the destination.
    function automatic logic [31:0] store_wdata(input logic [3:0]  op,
                                                input logic [31:0] v2);
        case (op)
            OP_SH:   return {2{v2[15:0]}};
            OP_SB:   return {4{v2[7:0]}};
            default: return v2;
        endcase
    endfunction

    // Halfword ops look only at a[1] and word ops ignore a, so misaligned low
    // bits fall away naturally when the alignment check is disabled.
    function automatic logic [31:0] load_extract(input logic [3:0]  op,
                                                 input logic [1:0]  a,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{a, 3'b000} +: 8];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'd0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    logic [1:0] a_m;
    logic       is_mem_m;
    logic       misaligned_m;
    logic       issue;

    // Context of the in-flight access, needed when the ack arrives.
    logic [3:0]  op_q;
    logic [1:0]  a_q;
    logic [31:0] pc_q;
    logic [4:0]  a3_q;

    assign a_m      = M_ALU_result[1:0];
    assign is_mem_m = is_load_op(M_mem_op) || is_store_op(M_mem_op);

`ifdef M_MEM_ALIGN_CHECK_EN
    logic [1:0] exc_q;
    assign misaligned_m = (((M_mem_op == OP_LW) || (M_mem_op == OP_SW)) && (a_m != 2'b00)) ||
                          (((M_mem_op == OP_LH) || (M_mem_op == OP_LHU) ||
                            (M_mem_op == OP_SH)) && a_m[0]);
    assign W_exc = exc_q;
`else
    assign misaligned_m = 1'b0;
    assign W_exc        = 2'b00;
`endif

    assign issue = (state == S_IDLE) && is_mem_m && !misaligned_m;

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (issue)   state_nxt = S_BUSY;
            S_BUSY:  if (mem_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---- FSM: outputs (stall releases in the ack cycle) ----
    always_comb begin
        stall = 1'b0;
        case (state)
            S_IDLE:  stall = issue;
            S_BUSY:  stall = !mem_ack;
            default: stall = 1'b0;
        endcase
    end

    // ---- M -> bus: request registered on the issue edge, held until ack ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_byteen <= 4'b0000;
            mem_wdata  <= 32'd0;
            op_q       <= 4'd0;
            a_q        <= 2'b00;
            pc_q       <= 32'd0;
            a3_q       <= 5'd0;
        end else if (issue) begin
            mem_req    <= 1'b1;
            mem_we     <= is_store_op(M_mem_op);
            mem_addr   <= {M_ALU_result[ADDR_W-1:2], 2'b00};
            mem_byteen <= store_byteen(M_mem_op, a_m);
            mem_wdata  <= store_wdata(M_mem_op, M_V2);
            op_q       <= M_mem_op;
            a_q        <= a_m;
            pc_q       <= M_PC;
            a3_q       <= M_A3;
        end else if ((state == S_BUSY) && mem_ack) begin
            mem_req    <= 1'b0;
        end
    end

    // ---- M/bus -> W ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            W_PC   <= 32'd0;
            W_A3   <= 5'd0;
            W_data <= 32'd0;
`ifdef M_MEM_ALIGN_CHECK_EN
            exc_q  <= 2'b00;
`endif
        end else if (state == S_IDLE) begin
            if (issue) begin
                // Bubble while the access is outstanding.
                W_A3   <= 5'd0;
`ifdef M_MEM_ALIGN_CHECK_EN
                exc_q  <= 2'b00;
            end else if (misaligned_m) begin
                W_PC   <= M_PC;
                W_A3   <= 5'd0;
                W_data <= M_ALU_result;
                exc_q  <= is_load_op(M_mem_op) ? 2'b01 : 2'b10;
`endif
            end else begin
                W_PC   <= M_PC;
                W_A3   <= M_A3;
                W_data <= M_ALU_result;
`ifdef M_MEM_ALIGN_CHECK_EN
                exc_q  <= 2'b00;
`endif
            end
        end else if (mem_ack) begin
            W_PC <= pc_q;
            W_A3 <= is_load_op(op_q) ? a3_q : 5'd0;
            if (is_load_op(op_q)) W_data <= load_extract(op_q, a_q, mem_rdata);
`ifdef M_MEM_ALIGN_CHECK_EN
            exc_q <= 2'b00;
`endif
        end else begin
            W_A3 <= 5'd0;
`ifdef M_MEM_ALIGN_CHECK_EN
            exc_q <= 2'b00;
`endif
        end
    end

endmodule

// File: tb/tb_m_mem_access.sv
module tb_m_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] M_PC;
    logic [4:0]  M_A3;
    logic [31:0] M_ALU_result;
    logic [31:0] M_V2;
    logic [3:0]  M_mem_op;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] W_PC;
    logic [4:0]  W_A3;
    logic [31:0] W_data;
    logic [1:0]  W_exc;

    int n_checks = 0;
    int n_pass   = 0;

    // Word-addressed reference memory (address bits [5:2]).
    logic [31:0] mem_model [16];

    always #5 clk = ~clk;

    m_mem_access #(.ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .M_PC         (M_PC),
        .M_A3         (M_A3),
        .M_ALU_result (M_ALU_result),
        .M_V2         (M_V2),
        .M_mem_op     (M_mem_op),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_byteen   (mem_byteen),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .stall        (stall),
        .W_PC         (W_PC),
        .W_A3         (W_A3),
        .W_data       (W_data),
        .W_exc        (W_exc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic bit op_is_load(input logic [3:0] op);
        return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    endfunction

    function automatic bit op_is_store(input logic [3:0] op);
        return op inside {4'd6, 4'd7, 4'd8};
    endfunction

    function automatic bit op_misaligned(input logic [3:0] op, input logic [31:0] addr);
`ifdef M_MEM_ALIGN_CHECK_EN
        if (op == 4'd1 || op == 4'd6) return (addr % 4) != 0;
        if (op == 4'd2 || op == 4'd3 || op == 4'd7) return (addr % 2) != 0;
        return 1'b0;
`else
        return (op == 4'hF) && (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_byteen(input logic [3:0] op, input logic [31:0] addr);
        int lane;
        lane = addr % 4;
        if (op == 4'd7) return (lane >= 2) ? 4'b1100 : 4'b0011;
        if (op == 4'd8) return 4'(1 << lane);
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] v2);
        logic [31:0] h, b;
        h = v2 % 32'h1_0000;
        b = v2 % 32'h100;
        if (op == 4'd7) return h * 32'h0001_0001;
        if (op == 4'd8) return b * 32'h0101_0101;
        return v2;
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> (8 * (addr % 4))) & 32'hFF;
        h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (op)
            4'd2:    return (h >= 32'h8000) ? h - 32'h1_0000 : h;
            4'd3:    return h;
            4'd4:    return (b >= 32'h80) ? b - 32'h100 : b;
            4'd5:    return b;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] apply_store(input logic [3:0] op, input logic [31:0] addr,
                                                input logic [31:0] v2, input logic [31:0] word);
        logic [31:0] w;
        int          lane;
        w    = word;
        lane = addr % 4;
        case (op)
            4'd6: w = v2;
            4'd7: if (lane >= 2) w[31:16] = v2[15:0]; else w[15:0] = v2[15:0];
            4'd8: w[8*lane +: 8] = v2[7:0];
            default: w = word;
        endcase
        return w;
    endfunction

    // Entered and left 1 time unit after a rising edge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] v2,
                          input logic [31:0] pc, input logic [4:0] a3, input int waits);
        int          idx;
        logic [31:0] r;
        idx          = (addr / 4) % 16;
        M_PC         = pc;
        M_A3         = a3;
        M_ALU_result = addr;
        M_V2         = v2;
        M_mem_op     = op;
        if (!(op_is_load(op) || op_is_store(op)) || op_misaligned(op, addr)) begin
            mem_ack   = 1'($urandom_range(0, 1));
            r         = $urandom;
            mem_rdata = r;
            @(negedge clk);
            chk("pass_stall", 32'(stall), 32'd0);
            chk("pass_req", 32'(mem_req), 32'd0);
            @(posedge clk); #1;
            chk("pass_W_PC", W_PC, pc);
            chk("pass_W_data", W_data, addr);
            if (op_misaligned(op, addr)) begin
                chk("fault_W_A3", 32'(W_A3), 32'd0);
                chk("fault_W_exc", 32'(W_exc), op_is_load(op) ? 32'd1 : 32'd2);
                chk("fault_req", 32'(mem_req), 32'd0);
            end else begin
                chk("pass_W_A3", 32'(W_A3), 32'(a3));
                chk("pass_W_exc", 32'(W_exc), 32'd0);
            end
            mem_ack = 1'b0;
            return;
        end
        mem_ack = 1'b0;
        @(negedge clk);
        chk("issue_stall", 32'(stall), 32'd1);
        chk("issue_req_low", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        chk("bus_req", 32'(mem_req), 32'd1);
        chk("bus_we", 32'(mem_we), 32'(op_is_store(op)));
        chk("bus_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("bus_byteen", 32'(mem_byteen), 32'(exp_byteen(op, addr)));
        if (op_is_store(op)) chk("bus_wdata", mem_wdata, exp_wdata(op, v2));
        chk("bubble_W_A3", 32'(W_A3), 32'd0);
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            chk("wait_stall", 32'(stall), 32'd1);
            @(posedge clk); #1;
            chk("wait_req", 32'(mem_req), 32'd1);
            chk("wait_addr", mem_addr, addr & 32'hFFFF_FFFC);
            chk("wait_W_A3", 32'(W_A3), 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = mem_model[idx];
        @(negedge clk);
        chk("ack_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("done_req", 32'(mem_req), 32'd0);
        chk("done_W_PC", W_PC, pc);
        chk("done_W_A3", 32'(W_A3), op_is_load(op) ? 32'(a3) : 32'd0);
        chk("done_W_exc", 32'(W_exc), 32'd0);
        if (op_is_load(op)) chk("load_W_data", W_data, exp_load(op, addr, mem_model[idx]));
        else mem_model[idx] = apply_store(op, addr, v2, mem_model[idx]);
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r_addr, r_v2, r_pc;
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        reset        = 1'b0;
        M_PC         = 32'd0;
        M_A3         = 5'd0;
        M_ALU_result = 32'd0;
        M_V2         = 32'd0;
        M_mem_op     = 4'd0;
        mem_ack      = 1'b0;
        mem_rdata    = 32'd0;
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_byteen", 32'(mem_byteen), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_W_PC", W_PC, 32'd0);
        chk("rst_W_A3", 32'(W_A3), 32'd0);
        chk("rst_W_data", W_data, 32'd0);
        chk("rst_W_exc", 32'(W_exc), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(4'd0, 32'h0000_1234, 32'd0, 32'h0000_0400, 5'd5, 0);
        mem_model[(32'h102 / 4) % 16] = 32'h00C4_0000;
        run_op(4'd4, 32'h0000_0102, 32'd0, 32'h0000_0404, 5'd7, 0);
        run_op(4'd7, 32'h0000_0206, 32'hABCD_1357, 32'h0000_0408, 5'd9, 3);
        run_op(4'd1, 32'h0000_0010, 32'd0, 32'h0000_040C, 5'd3, 0);
        run_op(4'd6, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0000_0410, 5'd4, 0);
        run_op(4'd1, 32'h0000_0003, 32'd0, 32'h0000_0414, 5'd6, 0);
        run_op(4'd2, 32'h0000_0003, 32'd0, 32'h0000_0418, 5'd6, 1);
        run_op(4'd8, 32'h0000_0023, 32'h0000_0080, 32'h0000_041C, 5'd1, 2);
        run_op(4'd11, 32'h0000_5555, 32'd0, 32'h0000_0420, 5'd2, 0);

        // Reset in the middle of an outstanding access
        run_op(4'd0, 32'h0000_0777, 32'd0, 32'h0000_0500, 5'd8, 0);
        M_mem_op     = 4'd1;
        M_ALU_result = 32'h0000_0020;
        M_PC         = 32'h0000_0504;
        @(posedge clk); #1;
        chk("mid_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_W_PC", W_PC, 32'd0);
        chk("mid_rst_W_data", W_data, 32'd0);
        chk("mid_rst_W_A3", 32'(W_A3), 32'd0);
        @(negedge clk);
        M_mem_op = 4'd0;
        reset    = 1'b1;
        @(posedge clk); #1;
        run_op(4'd1, 32'h0000_0020, 32'd0, 32'h0000_0508, 5'd10, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            r_addr = $urandom;
            r_v2   = $urandom;
            r_pc   = $urandom;
            run_op(4'($urandom_range(0, 15)), r_addr, r_v2, r_pc,
                   5'($urandom_range(0, 31)), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
